// File: rtl/bp_pkg.sv
// Types and immediate extraction shared by the bimodal and gshare branch predictors.
package bp_pkg;

    typedef enum logic {
        INIT,
        READY
    } bp_init_state_e;

    typedef enum logic [2:0] {
        NONE,
        B,
        J,
        CB,
        CJ
    } bp_br_type_e;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_cb(input logic [31:0] instr);
        return {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
    endfunction

    function automatic logic [31:0] imm_cj(input logic [31:0] instr);
        return {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                instr[2], instr[11], instr[5:3], 1'b0};
    endfunction

endpackage

// File: rtl/bp_gshare_if.sv
// Fetch-side prediction and EX-side training signals of the gshare predictor.
interface bp_gshare_if #(
    parameter int unsigned HistW = 8
);
    logic [31:0]      fetch_rdata_i;
    logic [31:0]      fetch_pc_i;
    logic             fetch_valid_i;
    logic             predict_branch_taken_o;
    logic [31:0]      predict_branch_pc_o;
    logic [HistW-1:0] predict_ghr_o;
    logic [31:0]      ex_br_instr_addr_i;
    logic             ex_br_taken_i;
    logic             ex_br_valid_i;
    logic [HistW-1:0] ex_br_ghr_i;
    logic             ex_br_mispredict_i;
    logic             init_busy_o;

    modport master (
        output fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        output ex_br_instr_addr_i, ex_br_taken_i, ex_br_valid_i, ex_br_ghr_i, ex_br_mispredict_i,
        input  predict_branch_taken_o, predict_branch_pc_o, predict_ghr_o, init_busy_o
    );

    modport slave (
        input  fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        input  ex_br_instr_addr_i, ex_br_taken_i, ex_br_valid_i, ex_br_ghr_i, ex_br_mispredict_i,
        output predict_branch_taken_o, predict_branch_pc_o, predict_ghr_o, init_busy_o
    );
endinterface

// File: rtl/bp_br_decode.sv
// Combinational branch-type decode and target adder for J, B, C.J/C.JAL and C.BEQZ/C.BNEZ.
module bp_br_decode
    import bp_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output bp_br_type_e br_type_o,
    output logic [31:0] target_o
);
    logic [31:0] imm;

    always_comb begin
        br_type_o = NONE;
        imm       = '0;
        if (instr_i[1:0] == 2'b11) begin
            if (instr_i[6:0] == 7'b1100011) begin
                br_type_o = B;
                imm       = imm_b(instr_i);
            end else if (instr_i[6:0] == 7'b1101111) begin
                br_type_o = J;
                imm       = imm_j(instr_i);
            end
        end else if (instr_i[1:0] == 2'b01) begin
            // Quadrant 1: funct3 001 is C.JAL (RV32), 101 C.J, 110/111 C.BEQZ/C.BNEZ
            case (instr_i[15:13])
                3'b001, 3'b101: begin
                    br_type_o = CJ;
                    imm       = imm_cj(instr_i);
                end
                3'b110, 3'b111: begin
                    br_type_o = CB;
                    imm       = imm_cb(instr_i);
                end
                default: ;
            endcase
        end
    end

    assign target_o = pc_i + imm;
endmodule

// File: rtl/bp_gshare.sv
// gshare predictor: counters indexed by PC ^ global history, swept to weakly-not-taken after reset.
// Define BP_GSHARE_SPEC_HIST_EN to index with a speculative history repaired on mispredict.
module bp_gshare
    import bp_pkg::*;
#(
    parameter int unsigned CTableSize = 1024,
    parameter int unsigned CounterLen = 2,
    parameter int unsigned HistLen    = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    bp_gshare_if.slave bp
);
    localparam int unsigned IdxW  = $clog2(CTableSize);
    localparam int unsigned HistW = (HistLen > 0) ? HistLen : 1;
    localparam logic [CounterLen-1:0] CtrInit = {1'b0, {(CounterLen-1){1'b1}}};
    localparam logic [CounterLen-1:0] CtrMax  = '1;

    function automatic logic [IdxW-1:0] hist_idx(input logic [HistW-1:0] h);
        return (HistLen == 0) ? '0 : IdxW'(h);
    endfunction

    function automatic logic [HistW-1:0] shift_in(input logic [HistW-1:0] h, input logic t);
        logic [HistW:0] ext;
        ext = {h, t};
        return (HistLen == 0) ? '0 : ext[HistW-1:0];
    endfunction

    logic [CounterLen-1:0] ctr_table [CTableSize];

    bp_init_state_e        state_q;
    logic [IdxW-1:0]       init_idx_q;
    logic [HistW-1:0]      ghr_q, ghr_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [IdxW-1:0]       upd_idx_q, upd_idx_d;
    logic [CounterLen-1:0] upd_ctr_q, upd_ctr_d;
    logic [CounterLen-1:0] upd_base;
    logic [IdxW-1:0]       ex_idx, fetch_idx;
    logic [HistW-1:0]      hist;
    logic                  ready;
    logic                  wr_en;
    logic [IdxW-1:0]       wr_idx;
    logic [CounterLen-1:0] wr_data;
    logic [CounterLen-1:0] pred_ctr;
    bp_br_type_e           br_type;

    assign ready = (state_q == READY);

    bp_br_decode u_decode (
        .instr_i   (bp.fetch_rdata_i),
        .pc_i      (bp.fetch_pc_i),
        .br_type_o (br_type),
        .target_o  (bp.predict_branch_pc_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else if (state_q == INIT) begin
            init_idx_q <= init_idx_q + IdxW'(1);
            if (init_idx_q == IdxW'(CTableSize - 1)) begin
                state_q <= READY;
            end
        end
    end

    // Capture computes the new counter now, forwarding the still-pending write on an idx match
    assign ex_idx = bp.ex_br_instr_addr_i[IdxW+1:2] ^ hist_idx(bp.ex_br_ghr_i);

    always_comb begin
        upd_valid_d = ready & bp.ex_br_valid_i;
        upd_idx_d   = ex_idx;
        upd_base    = (upd_valid_q && (upd_idx_q == ex_idx)) ? upd_ctr_q : ctr_table[ex_idx];
        if (bp.ex_br_taken_i) begin
            upd_ctr_d = (upd_base == CtrMax) ? upd_base : upd_base + CounterLen'(1);
        end else begin
            upd_ctr_d = (upd_base == '0) ? upd_base : upd_base - CounterLen'(1);
        end
        ghr_d = upd_valid_d ? shift_in(ghr_q, bp.ex_br_taken_i) : ghr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_ctr_q   <= CtrInit;
            ghr_q       <= '0;
        end else begin
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_ctr_q   <= upd_ctr_d;
            ghr_q       <= ghr_d;
        end
    end

    // Single write port shared by the sweep and the training stage
    always_comb begin
        wr_en   = ~rst_i & (ready ? upd_valid_q : 1'b1);
        wr_idx  = ready ? upd_idx_q : init_idx_q;
        wr_data = ready ? upd_ctr_q : CtrInit;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ctr_table[wr_idx] <= wr_data;
        end
    end

`ifdef BP_GSHARE_SPEC_HIST_EN
    logic [HistW-1:0] sghr_q, sghr_d;

    always_comb begin
        sghr_d = sghr_q;
        if (ready) begin
            if (bp.ex_br_valid_i & bp.ex_br_mispredict_i) begin
                sghr_d = shift_in(bp.ex_br_ghr_i, bp.ex_br_taken_i);
            end else if (bp.fetch_valid_i & ((br_type == B) | (br_type == CB))) begin
                sghr_d = shift_in(sghr_q, bp.predict_branch_taken_o);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sghr_q <= '0;
        end else begin
            sghr_q <= sghr_d;
        end
    end

    assign hist = rst_i ? '0 : sghr_q;
`else
    assign hist = rst_i ? '0 : ghr_q;
`endif

    assign fetch_idx        = bp.fetch_pc_i[IdxW+1:2] ^ hist_idx(hist);
    assign pred_ctr         = ctr_table[fetch_idx];
    assign bp.init_busy_o   = rst_i | (state_q == INIT);
    assign bp.predict_ghr_o = hist;
    assign bp.predict_branch_taken_o = bp.fetch_valid_i &
        ((br_type == J) | (br_type == CJ) |
         (((br_type == B) | (br_type == CB)) & pred_ctr[CounterLen-1] & ~bp.init_busy_o));
endmodule

// File: doc/bp_gshare.md
# bp_gshare

Parametrised gshare conditional-branch predictor for the Ibex fetch stage, and the successor to the bimodal predictor. It indexes a table of saturating counters with PC bits XORed with a global history register (GHR). It clears the table with a post-reset sweep FSM and writes training updates through a registered stage with forwarding. Fetch-side prediction is same-cycle; training comes from the EX stage.

## Interface
- `CTableSize`, 1024: number of counters; power of two, ≥ 16. Index width `IdxW = $clog2(CTableSize)`.
- `CounterLen`, 2: counter width in bits; ≥ 2.
- `HistLen`, 8: GHR length; 0..IdxW. A value of 0 gives pure bimodal indexing. History port width `HistW = max(HistLen,1)`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `fetch_rdata_i` in 32: instruction word (compressed instructions in `[15:0]`).
- `fetch_pc_i` in 32: PC of `fetch_rdata_i`.
- `fetch_valid_i` in 1: fetch word is valid.
- `predict_branch_taken_o` out 1: predicted taken.
- `predict_branch_pc_o` out 32: predicted target, `fetch_pc_i + imm`.
- `predict_ghr_o` out HistW: history used for this prediction. It is carried down the pipe with the instruction.
- `ex_br_instr_addr_i` in 32: PC of the resolved conditional branch.
- `ex_br_taken_i` in 1: resolved direction.
- `ex_br_valid_i` in 1: resolution valid. Asserted for conditional branches only.
- `ex_br_ghr_i` in HistW: `predict_ghr_o` value that was captured for this branch.
- `ex_br_mispredict_i` in 1: resolved direction differed from the prediction. Qualified by `ex_br_valid_i`.
- `init_busy_o` out 1: table sweep in progress.

## Operation
- Decode covers J, B, CJ (`C.J`/`C.JAL`) and CB (`C.BEQZ`/`C.BNEZ`), with immediates identical to the bimodal predictor.
- Prediction index: `fetch_pc_i[IdxW+1:2] ^ {zero-ext hist}`.
  - `hist` is the speculative GHR when the macro is on, otherwise the committed GHR.
- Counters are unsigned and saturating. MSB = 1 means taken. Reset/init value is `2^(CounterLen-1)-1` (weakly not-taken).
- `predict_branch_taken_o = fetch_valid_i & (J | CJ | ((B | CB) & ctr_msb & ~init_busy_o))`.
- FSM states:
  - INIT: entered on `rst_i`. Writes one entry per cycle, index 0..CTableSize-1, with the init value. Moves to READY after the last entry. `init_busy_o` = 1.
  - READY: normal operation. `init_busy_o` = 0.
- During INIT all EX updates are dropped and the GHRs do not change.
- Update stage:
  - Capture: on `ex_br_valid_i` in READY, register `idx = ex_br_instr_addr_i[IdxW+1:2] ^ ex_br_ghr_i` and `taken`.
  - Write: next cycle, read-modify-write ±1 with saturation at 0 and at `2^CounterLen-1`.
  - Back-to-back updates to the same idx: the second update uses the forwarded pending value, so both increments are applied.
- Committed GHR: on each valid update, becomes `{ghr[HistLen-2:0], ex_br_taken_i}`.
- Reset: `rst_i` at any time, including mid-sweep, clears both GHRs and the update stage and restarts INIT at index 0.

## Timing
- Prediction outputs are combinational from the fetch inputs and registered state. No fetch-side latency.
- Counter update: captured at edge N (the edge where `ex_br_valid_i` = 1), written at edge N+1. Visible to prediction from cycle N+1 onward.
- Committed GHR updates at edge N.
- A prediction reading the entry being written in the same cycle sees the old value.
- INIT lasts exactly CTableSize cycles after the cycle in which `rst_i` is deasserted.
- Output values during reset:
  - `init_busy_o` = 1.
  - `predict_ghr_o` = 0.
  - `predict_branch_taken_o` = 1 only for J/CJ with `fetch_valid_i`.

## Configuration
- `BP_GSHARE_SPEC_HIST_EN`: compiles in the speculative GHR.
  - Defined:
    - Each valid B/CB fetch in READY shifts the speculative GHR one cycle later, shifting in the predicted direction.
    - On `ex_br_valid_i & ex_br_mispredict_i`, the speculative GHR becomes `{ex_br_ghr_i[HistLen-2:0], ex_br_taken_i}`. A mispredict wins over a simultaneous fetch shift.
    - `predict_ghr_o` is the speculative GHR.
  - Undefined: the speculative GHR is absent, `ex_br_mispredict_i` is ignored, and prediction and `predict_ghr_o` use the committed GHR.

## Structure
- Shared package `bp_pkg` holds:
  - `bp_init_state_e` with values INIT and READY.
  - The immediate-extract functions.
  - The `bp_br_type_e` enum with values NONE, B, J, CB and CJ.
- One sub-module, `bp_br_decode`: combinational branch-type and immediate decode plus target adder. It is shared with the bimodal predictor.

## Test plan
Parameters for all scenarios: CTableSize=16, CounterLen=2, HistLen=4.
- Reset sweep: pulse `rst_i` for 1 cycle.
  - `init_busy_o` is 1 for exactly 16 cycles.
  - During INIT, BEQ `0x00000463` at 0x100 → not taken.
  - During INIT, JAL at 0x100 → taken.
- Forwarding (macro off): `ex_br_valid_i` on 2 consecutive cycles, PC 0x40, ghr_i 0, taken.
  - Counter[0] goes 01 → 11 and committed GHR = 0011.
  - Then BEQ `0x00000463` at 0x0C → taken, target 0x14.
- Saturation: continuing from the previous scenario, 3 further taken updates to idx 0 (PC 0x40, ghr_i 0) leave the counter at 11.
  - 5 not-taken updates leave it at 00.
  - BEQ at 0x0C with GHR 0000 → not taken.
- Mispredict recovery (macro on): `ex_br_valid_i`, `ex_br_mispredict_i`, ghr_i 0101, taken=1 → `predict_ghr_o` = 1011 next cycle.
  - Repeat with a simultaneous B fetch: the result is still 1011.
- Reset mid-sweep: assert `rst_i` at INIT cycle 5.
  - `init_busy_o` stays high for 16 cycles after deassertion.
  - An EX update issued during INIT leaves its entry at 01.
- Compressed jump: C.J `0xA001` (offset 0) at 0x200 → taken, target 0x200.
  - C.BEQZ with a weak counter → not taken.
